// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority-vote sampling; define UART_RX_BREAK_DET_EN for line-break detection
module uart_rx_core #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [3:0]         data_len,
  input  logic               par_en,
  input  logic               par_odd,
  input  logic               stop2,
  output logic [DATA_W-1:0]  rx_data,
  output logic               data_valid,
  output logic               parity_error,
  output logic               stop_error,
  output logic               break_det
);
`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`endif
  localparam logic [3:0] DW = 4'(DATA_W);
  state_t st, nxt;
  logic [1:0] sync;
  logic rxs, maj, bit_end, last_stop, go, is_brk;
  logic [PRESC_W-1:0] edge_cnt, pr, h0, hm1, hp1, hp2, pm1, pm2;
  logic [3:0] bit_cnt, len, len_in;
  logic pe_l, po_l, s2_l, stop_cnt, perr, serr;
  logic [2:0] smp;
  logic [DATA_W-1:0] word;
  logic dv_d, pe_d, se_d, bd_d;

  assign rxs = sync[1];
  assign len_in = (data_len < 4'd5 || data_len > DW) ? DW : data_len;
  assign h0 = pr >> 1;
  assign hm1 = h0 - PRESC_W'(1);
  assign hp1 = h0 + PRESC_W'(1);
  assign hp2 = h0 + PRESC_W'(2);
  assign pm1 = pr - PRESC_W'(1);
  assign pm2 = pr - PRESC_W'(2);
  assign maj = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign bit_end = edge_cnt == pm1;
  assign last_stop = !s2_l || stop_cnt;
  assign go = nxt == START && st != START;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:   nxt = rxs ? IDLE : START;
      START:  nxt = (edge_cnt == hp2 && maj) ? IDLE : bit_end ? DATA : START;
      DATA:   nxt = (bit_end && bit_cnt == len - 4'd1) ? (pe_l ? PARITY : STOP) : DATA;
      PARITY: nxt = bit_end ? STOP : PARITY;
      STOP:   nxt = (edge_cnt == pm2 && last_stop) ? DONE : STOP;
`ifdef UART_RX_BREAK_DET_EN
      DONE:   nxt = is_brk ? BRK : rxs ? IDLE : START;
      BRK:    nxt = rxs ? IDLE : BRK;
`else
      DONE:   nxt = rxs ? IDLE : START;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync     <= 2'b11;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      smp      <= '0;
      word     <= '0;
      perr     <= 1'b0;
      serr     <= 1'b0;
      pr       <= '0;
      len      <= '0;
      pe_l     <= 1'b0;
      po_l     <= 1'b0;
      s2_l     <= 1'b0;
    end else begin
      sync     <= {sync[0], rx_in};
      edge_cnt <= (nxt == IDLE || st == IDLE || bit_end) ? '0 : edge_cnt + 1'b1;
      if (edge_cnt == hm1 || edge_cnt == h0 || edge_cnt == hp1) smp <= {smp[1:0], rxs};
      if (go) begin
        pr       <= prescale;
        len      <= len_in;
        pe_l     <= par_en;
        po_l     <= par_odd;
        s2_l     <= stop2;
        word     <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr     <= 1'b0;
        serr     <= 1'b0;
      end
      if (st == DATA && bit_end) begin
        word    <= word | (DATA_W'(maj) << bit_cnt);
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (st == PARITY && bit_end) perr <= (^word ^ maj) != po_l;
      if (st == STOP && edge_cnt == hp2 && !maj) serr <= 1'b1;
      if (st == STOP && bit_end) stop_cnt <= 1'b1;
    end

`ifdef UART_RX_BREAK_DET_EN
  logic nz, s1z;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nz  <= 1'b0;
      s1z <= 1'b0;
    end else begin
      if (go) nz <= 1'b0;
      else if ((st == DATA || st == PARITY) && bit_end && maj) nz <= 1'b1;
      if (st == STOP && !stop_cnt && edge_cnt == hp2) s1z <= !maj;
    end
  assign is_brk = !nz && s1z;
`else
  assign is_brk = 1'b0;
`endif

  always_comb begin
    dv_d = st == DONE && !is_brk && !perr && !serr;
    pe_d = st == DONE && !is_brk && perr;
    se_d = st == DONE && !is_brk && serr;
    bd_d = st == DONE && is_brk;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data      <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      data_valid   <= dv_d;
      parity_error <= pe_d;
      stop_error   <= se_d;
      break_det    <= bd_d;
      if (dv_d) rx_data <= word;
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frames against a frame-level reference model with a scoreboard monitor
module tb_uart_rx_core;
  logic clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
  logic [7:0] rx_data;
  logic data_valid, parity_error, stop_error, break_det;
  int checks = 0, errors = 0, n_exp = 0, n_got = 0;
  logic [11:0] sb[$];
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .prescale(prescale), .data_len(data_len),
    .par_en(par_en), .par_odd(par_odd), .stop2(stop2), .rx_data(rx_data),
    .data_valid(data_valid), .parity_error(parity_error), .stop_error(stop_error),
    .break_det(break_det)
  );

  always @(negedge clk) begin : mon
    logic [11:0] act, e;
    if (rst_n && (data_valid || parity_error || stop_error || break_det)) begin
      act = {data_valid, parity_error, stop_error, break_det, rx_data};
      n_got++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got %h expected none", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL frame got {dv,pe,se,bd,data}=%h expected %h", act, e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic drive(input bit v, input int p);
    rx_in = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic frame(input int p, input int dl, input bit pe, input bit po, input bit s2,
                       input logic [7:0] data, input bit pflip, input bit st1, input bit st2b,
                       input int gap);
    int eff;
    logic [7:0] d;
    bit pbit, brk, perr, serr;
    eff = (dl < 5 || dl > 8) ? 8 : dl;
    d = data & 8'((1 << eff) - 1);
    pbit = po ^ (^d) ^ pflip;
    brk = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk = d == 8'h00 && (!pe || !pbit) && !st1;
`endif
    perr = pe && pflip;
    serr = !st1 || (s2 && !st2b);
    if (brk) sb.push_back({4'b0001, last_good});
    else if (perr || serr) sb.push_back({1'b0, perr, serr, 1'b0, last_good});
    else begin
      last_good = d;
      sb.push_back({4'b1000, d});
    end
    n_exp++;
    if (brk && gap < 4) gap = 4;
    prescale = 6'(p);
    data_len = 4'(dl);
    par_en = pe;
    par_odd = po;
    stop2 = s2;
    drive(1'b0, p);
    prescale = 6'($urandom);
    data_len = 4'($urandom);
    par_en = 1'($urandom);
    par_odd = 1'($urandom);
    stop2 = 1'($urandom);
    for (int i = 0; i < eff; i++) drive(d[i], p);
    if (pe) drive(pbit, p);
    drive(st1, p);
    if (s2) drive(st2b, p);
    rx_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #12;
    checks++;
    if ({data_valid, parity_error, stop_error, break_det, rx_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold got %b%b%b%b %h expected 0000 00", data_valid, parity_error, stop_error, break_det, rx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({data_valid, parity_error, stop_error, break_det, rx_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got %b%b%b%b %h expected 0000 00", data_valid, parity_error, stop_error, break_det, rx_data);
    end
    frame(8, 8, 1, 0, 0, 8'hA5, 0, 1, 1, 16);
    frame(8, 8, 1, 0, 0, 8'h3C, 1, 1, 1, 16);
    frame(16, 5, 0, 0, 1, 8'h15, 0, 1, 0, 32);
    prescale = 6'd8;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    frame(8, 8, 1, 0, 0, 8'h5A, 0, 1, 1, 16);
    frame(8, 8, 1, 1, 0, 8'h01, 0, 1, 1, 0);
    frame(8, 8, 1, 1, 0, 8'hFF, 0, 1, 1, 16);
    prescale = 6'd8;
    data_len = 4'd7;
    par_en = 1'b1;
    par_odd = 1'b0;
    stop2 = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    sb.push_back({4'b0001, last_good});
    n_exp += 1;
`else
    sb.push_back({4'b0010, last_good});
    sb.push_back({4'b0010, last_good});
    n_exp += 2;
`endif
    rx_in = 1'b0;
    repeat (160) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    frame(12, 9, 0, 0, 0, 8'hC3, 0, 1, 1, 24);
    frame(10, 3, 1, 1, 1, 8'h7E, 0, 1, 1, 20);
    for (int k = 0; k < 40; k++) begin
      int p, gap;
      p = 8 + 2 * $urandom_range(0, 6);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * p);
      frame(p, $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, gap);
    end
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    prescale = 6'd8;
    data_len = 4'd8;
    par_en = 1'b0;
    stop2 = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 8);
    drive(1'b1, 8);
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    checks++;
    if ({data_valid, parity_error, stop_error, break_det, rx_data} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset got %b%b%b%b %h expected 0000 00", data_valid, parity_error, stop_error, break_det, rx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (100) @(negedge clk);
    frame(10, 6, 0, 0, 0, 8'h2B, 0, 1, 1, 20);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    checks++;
    if (n_got != n_exp) begin
      errors++;
      $display("FAIL pulse_count got %0d expected %0d", n_got, n_exp);
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++;
      $display("FAIL final_data got %h expected %h", rx_data, last_good);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
